// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port count, port IDs and the per-output
// allocation state used by the switch allocator.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  typedef logic [2:0] port_id_t;

  localparam port_id_t PORT_LOCAL = 3'd0;
  localparam port_id_t PORT_WEST  = 3'd1;
  localparam port_id_t PORT_NORTH = 3'd2;
  localparam port_id_t PORT_EAST  = 3'd3;
  localparam port_id_t PORT_SOUTH = 3'd4;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_e;

  function automatic port_id_t onehot_to_id(input logic [NUM_PORTS-1:0] oh);
    port_id_t id;
    id = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) id = port_id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after ptr, searching upward with wrap-around.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_id_t             ptr,
  output logic [NUM_PORTS-1:0] grant
);

  logic [3:0] idx;
  logic       found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NUM_PORTS)) idx = idx - 4'(NUM_PORTS);
      if (!found && (idx < 4'(NUM_PORTS)) && req[idx[2:0]]) begin
        grant[idx[2:0]] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Packet-granular switch allocator: each output locks onto one input from
// head to tail flit, choosing among competing heads round-robin.
module switch_allocator #(
  parameter int NUM_PORTS = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]   in_valid,
  input  logic [NUM_PORTS-1:0]   in_head,
  input  logic [NUM_PORTS-1:0]   in_tail,
  input  logic [3*NUM_PORTS-1:0] in_port_req,
  input  logic [NUM_PORTS-1:0]   out_ready,
  output logic [NUM_PORTS-1:0]   in_grant,
  output logic [NUM_PORTS-1:0]   out_valid,
  output logic [3*NUM_PORTS-1:0] xbar_sel
);
  import noc_pkg::*;

  out_state_e           state_q [NUM_PORTS];
  out_state_e           state_d [NUM_PORTS];
  port_id_t             owner_q [NUM_PORTS];
  port_id_t             owner_d [NUM_PORTS];
  port_id_t             ptr_q   [NUM_PORTS];
  port_id_t             ptr_d   [NUM_PORTS];
  port_id_t             req_id  [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_req [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_gnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] owns;
  logic                 xfer;

  // An input already holding an output may not compete for another one.
  always_comb begin
    owns = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == OUT_LOCKED) owns[owner_q[o]] = 1'b1;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_id[i] = in_port_req[3*i +: 3];
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        arb_req[o][i] = in_valid[i] & in_head[i] & ~owns[i] &
                        (req_id[i] == port_id_t'(o));
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter u_arb (
      .req   (arb_req[g]),
      .ptr   (ptr_q[g]),
      .grant (arb_gnt[g])
    );
  end

  always_comb begin
    in_grant  = '0;
    out_valid = '0;
    xbar_sel  = '0;
    xfer      = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (state_q[o] == OUT_LOCKED) begin
        out_valid[o]      = in_valid[owner_q[o]];
        xbar_sel[3*o +: 3] = owner_q[o];
        xfer              = in_valid[owner_q[o]] & out_ready[o];
        if (xfer) in_grant[owner_q[o]] = 1'b1;
        if (xfer && in_tail[owner_q[o]]) begin
          state_d[o] = OUT_IDLE;
          ptr_d[o]   = (owner_q[o] == port_id_t'(NUM_PORTS-1)) ? '0 : owner_q[o] + 3'd1;
        end
      end else if (|arb_gnt[o]) begin
        // Grant is registered into the lock; the first pop comes next cycle.
        state_d[o] = OUT_LOCKED;
        owner_d[o] = onehot_to_id(arb_gnt[o]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= OUT_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

endmodule
